ifu_prefetch: RTL and testbench

- Prefetch stage sitting directly upstream of the fetch stage.
- Generates sequential fetch addresses and drives the instruction-bus read handshake.
- Forwards each returned instruction and its address, one registered cycle later, to fill the fetch stage's 16-entry direct-mapped I-Cache.
- Restarts a 16-word fill at the current PC whenever the fetch stage reports a miss; otherwise idles once the cache reports full.

---
 rtl/ifu_prefetch.sv | 137 +++++++++++++
 tb/tb_ifu_prefetch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction prefetch stage that fills the fetch stage's
// direct-mapped I-Cache.
//
// It walks FILL_WORDS sequential word addresses from a base address,
// requests each one on the instruction bus, and forwards every returned
// word with its address one registered cycle later. A fill starts at
// PC_INIT after reset, and again at the aligned PcIn on every cache miss
// seen while the block is not filling.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FILL      | requesting words; each bus handshake advances the address
// WAIT_FULL | fill done; waiting for the cache to report full (or a miss)
// IDLE      | cache full; waiting for a miss to start a refill
//
// Ports:
//   Clk            in   clock, rising edge
//   Rst            in   synchronous reset, active low
//   CacheFull      in   every cache line is valid
//   CacheMissing   in   current PC not present in the cache
//   PcIn           in   current PC, used as the refill base
//   ReadData       in   instruction returned by the bus
//   ReadValid      in   bus data valid (handshake = ReadReq && ReadValid)
//   ReadReq        out  bus read request
//   ReadAddr       out  bus read address, word aligned
//   PrePcOut       out  address of the forwarded instruction
//   InstOut        out  forwarded instruction
//   ReadShakeHands out  one-cycle write strobe for PrePcOut/InstOut
//   FillBusy       out  high in FILL and WAIT_FULL
module ifu_prefetch #(
  parameter int          ADDR_W     = 64,
  parameter int          INST_W     = 32,
  parameter int          FILL_WORDS = 16,
  parameter logic [63:0] PC_INIT    = 64'h0000_0000_8000_0000
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              CacheFull,
  input  logic              CacheMissing,
  input  logic [ADDR_W-1:0] PcIn,
  input  logic [INST_W-1:0] ReadData,
  input  logic              ReadValid,
  output logic              ReadReq,
  output logic [ADDR_W-1:0] ReadAddr,
  output logic [ADDR_W-1:0] PrePcOut,
  output logic [INST_W-1:0] InstOut,
  output logic              ReadShakeHands,
  output logic              FillBusy
);

  localparam int CNT_W = (FILL_WORDS > 1) ? $clog2(FILL_WORDS) : 1;
  localparam logic [ADDR_W-1:0] PC_START = PC_INIT[ADDR_W-1:0];

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    WAIT_FULL = 2'd1,
    IDLE      = 2'd2
  } state_t;

  state_t             state, stateNext;
  logic [ADDR_W-1:0]  fillAddr, fillAddrNext;
  logic [CNT_W-1:0]   count, countNext;
  logic               handshake;
  logic [ADDR_W-1:0]  refillBase;
  logic               unusedPcLow;

  assign refillBase  = {PcIn[ADDR_W-1:2], 2'b00};
  assign unusedPcLow = ^PcIn[1:0];

  // Request is gated by reset so a handshake in a reset cycle cannot occur.
  assign ReadReq   = Rst && (state == FILL);
  assign ReadAddr  = Rst ? {fillAddr[ADDR_W-1:2], 2'b00} : PC_START;
  assign FillBusy  = (state == FILL) || (state == WAIT_FULL);
  assign handshake = ReadReq && ReadValid;

  always_comb begin
    stateNext    = state;
    fillAddrNext = fillAddr;
    countNext    = count;
    case (state)
      FILL: begin
        if (handshake) begin
          fillAddrNext = fillAddr + ADDR_W'(4);
          if (count == CNT_W'(FILL_WORDS - 1)) begin
            stateNext = WAIT_FULL;
            countNext = '0;
          end else begin
            countNext = count + CNT_W'(1);
          end
        end
      end
      WAIT_FULL: begin
        // A miss outranks full: the cache holds the wrong lines for the PC.
        if (CacheMissing) begin
          stateNext    = FILL;
          fillAddrNext = refillBase;
          countNext    = '0;
        end else if (CacheFull) begin
          stateNext = IDLE;
        end
      end
      IDLE: begin
        if (CacheMissing) begin
          stateNext    = FILL;
          fillAddrNext = refillBase;
          countNext    = '0;
        end
      end
      default: begin
        stateNext    = FILL;
        fillAddrNext = PC_START;
        countNext    = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state          <= FILL;
      fillAddr       <= PC_START;
      count          <= '0;
      PrePcOut       <= PC_START;
      InstOut        <= '0;
      ReadShakeHands <= 1'b0;
    end else begin
      state          <= stateNext;
      fillAddr       <= fillAddrNext;
      count          <= countNext;
      ReadShakeHands <= handshake;
      if (handshake) begin
        PrePcOut <= ReadAddr;
        InstOut  <= ReadData;
      end
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
module tb_ifu_prefetch;

  localparam logic [63:0] PC_INIT = 64'h0000_0000_8000_0000;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        CacheFull = 1'b0;
  logic        CacheMissing = 1'b0;
  logic [63:0] PcIn = '0;
  logic [31:0] ReadData = '0;
  logic        ReadValid = 1'b0;
  logic        ReadReq;
  logic [63:0] ReadAddr;
  logic [63:0] PrePcOut;
  logic [31:0] InstOut;
  logic        ReadShakeHands;
  logic        FillBusy;

  ifu_prefetch dut (
    .Clk(Clk), .Rst(Rst), .CacheFull(CacheFull), .CacheMissing(CacheMissing),
    .PcIn(PcIn), .ReadData(ReadData), .ReadValid(ReadValid),
    .ReadReq(ReadReq), .ReadAddr(ReadAddr), .PrePcOut(PrePcOut),
    .InstOut(InstOut), .ReadShakeHands(ReadShakeHands), .FillBusy(FillBusy)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int dutPulses = 0;
  bit checkEn = 1'b0;

  // Model: a fill is "base + 4*words" for words = 0..15; phase says
  // whether the block is fetching, done-and-waiting, or parked.
  localparam int PH_FETCH = 0, PH_DONE = 1, PH_PARKED = 2;
  int          mPhase = PH_FETCH;
  logic [63:0] mBase  = PC_INIT;
  int          mWords = 0;
  logic [63:0] mAddr  = PC_INIT;
  logic        mPulse = 1'b0;
  logic [63:0] mPrePc = PC_INIT;
  logic [31:0] mInst  = '0;

  always @(posedge Clk) begin
    if (!Rst) begin
      mPhase = PH_FETCH; mBase = PC_INIT; mWords = 0;
      mPulse = 1'b0; mPrePc = PC_INIT; mInst = '0;
    end else begin
      mPulse = (mPhase == PH_FETCH) && ReadValid;
      if (mPulse) begin
        mPrePc = mAddr;
        mInst  = ReadData;
        mWords = mWords + 1;
        if (mWords == 16) mPhase = PH_DONE;
      end else if (mPhase != PH_FETCH && CacheMissing) begin
        mPhase = PH_FETCH;
        mBase  = PcIn & ~64'h3;
        mWords = 0;
      end else if (mPhase == PH_DONE && CacheFull) begin
        mPhase = PH_PARKED;
      end
    end
    mAddr = (mPhase == PH_FETCH) ? mBase + 64'(4 * mWords) : mBase + 64'd64;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (checkEn) begin
      chk("ReadReq", 64'(ReadReq), 64'(Rst && mPhase == PH_FETCH));
      if (Rst && mPhase == PH_FETCH) chk("ReadAddr", ReadAddr, mAddr);
      if (!Rst) chk("ReadAddrRst", ReadAddr, PC_INIT);
      chk("FillBusy", 64'(FillBusy), 64'(mPhase != PH_PARKED));
      chk("ReadShakeHands", 64'(ReadShakeHands), 64'(mPulse));
      chk("PrePcOut", PrePcOut, mPrePc);
      chk("InstOut", 64'(InstOut), 64'(mInst));
      if (ReadShakeHands) dutPulses++;
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Drive one fill to completion; optionally stall the bus at one word.
  task automatic runFill(input int stallWord, input int stallLen, input logic [63:0] stallAddr);
    int stalled = 0;
    int budget = 200;
    dutPulses = 0;
    while (mPhase == PH_FETCH && budget > 0) begin
      ReadData = mAddr[31:0];
      if (mWords == stallWord && stalled < stallLen) begin
        ReadValid = 1'b0;
        stalled++;
        @(negedge Clk);
        chk("stallAddr", ReadAddr, stallAddr);
        chk("stallReq", 64'(ReadReq), 64'd1);
      end else begin
        ReadValid = 1'b1;
      end
      step();
      budget--;
    end
    if (budget == 0) begin
      errors++;
      $display("FAIL fillTimeout actual=%0d expected=16 words", mWords);
    end
    ReadValid = 1'b0;
    step();
    step();
    chk("pulseCount", 64'(dutPulses), 64'd16);
  endtask

  task automatic park();
    CacheFull = 1'b1;
    step();
    CacheFull = 1'b0;
    @(negedge Clk);
    chk("parkedBusy", 64'(FillBusy), 64'd0);
    chk("parkedReq", 64'(ReadReq), 64'd0);
    step();
  endtask

  task automatic miss(input logic [63:0] pc, input logic [63:0] expAddr);
    PcIn = pc;
    CacheMissing = 1'b1;
    step();
    CacheMissing = 1'b0;
    @(negedge Clk);
    chk("missReq", 64'(ReadReq), 64'd1);
    chk("missAddr", ReadAddr, expAddr);
  endtask

  initial begin
    // Reset
    step(); step();
    checkEn = 1'b1;
    @(negedge Clk);
    chk("rstReq", 64'(ReadReq), 64'd0);
    chk("rstPrePc", PrePcOut, PC_INIT);
    Rst = 1'b1;
    @(negedge Clk);
    chk("firstAddr", ReadAddr, 64'h8000_0000);

    // 1: straight fill from PC_INIT
    runFill(-1, 0, '0);
    chk("t1LastPc", PrePcOut, 64'h8000_003C);
    chk("t1LastInst", 64'(InstOut), 64'h8000_003C);
    chk("t1WaitReq", 64'(ReadReq), 64'd0);
    chk("t1WaitBusy", 64'(FillBusy), 64'd1);
    park();

    // 2: five-cycle stall at word 3
    miss(64'h8000_0000, 64'h8000_0000);
    runFill(3, 5, 64'h8000_000C);
    park();

    // 3: unaligned refill base
    miss(64'h8000_1236, 64'h8000_1234);
    runFill(-1, 0, '0);
    chk("t3LastPc", PrePcOut, 64'h8000_1270);
    park();

    // 4: reset at word 7
    miss(64'h8000_4000, 64'h8000_4000);
    ReadValid = 1'b1;
    for (int i = 0; i < 40 && mWords < 7; i++) begin
      ReadData = mAddr[31:0];
      step();
    end
    chk("t4Word", 64'(mWords), 64'd7);
    Rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge Clk);
      chk("t4RstPulse", 64'(ReadShakeHands), 64'd0);
      chk("t4RstPrePc", PrePcOut, PC_INIT);
      chk("t4RstInst", 64'(InstOut), 64'd0);
      chk("t4RstAddr", ReadAddr, PC_INIT);
    end
    Rst = 1'b1;
    ReadValid = 1'b0;
    @(negedge Clk);
    chk("t4RestartAddr", ReadAddr, 64'h8000_0000);
    runFill(-1, 0, '0);
    chk("t4LastPc", PrePcOut, 64'h8000_003C);
    park();

    // 5: address wrap
    miss(64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8);
    runFill(-1, 0, '0);
    chk("t5LastPc", PrePcOut, 64'h0000_0000_0000_0034);
    chk("t5LastInst", 64'(InstOut), 64'h0000_0034);

    // 6: miss and full together while waiting; miss wins
    CacheFull = 1'b1;
    miss(64'h8000_2005, 64'h8000_2004);
    CacheFull = 1'b0;
    chk("t6Busy", 64'(FillBusy), 64'd1);
    runFill(-1, 0, '0);
    chk("t6LastPc", PrePcOut, 64'h8000_2040);
    park();

    checkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
